// File: rtl/uart_core.sv
// uart_core: single-clock UART transceiver.
// A clock-enable tick generator paces both directions. TX takes bytes
// through a valid/ready handshake. RX oversamples the line, validates the
// start bit and reports parity and framing errors. Loopback routes the
// internal TX stream into RX and parks the txd pin high.

module uart_core #(
    parameter int CLK_FREQ    = 100_000_000,
    parameter int BAUD_RATE   = 9_600,
    parameter int DATA_WIDTH  = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_WIDTH  = 1,
    parameter int OVERSAMPLE  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  txd,
    input  logic                  rxd,
    input  logic                  loopback,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  rx_parity_err,
    output logic                  rx_frame_err
);

    localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CNT_W   = $clog2(OVERSAMPLE);
    localparam int BIT_W   = $clog2(DATA_WIDTH);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic             STOP_LAST  = (STOP_WIDTH == 2);
    localparam logic             HAS_PARITY = (PARITY_MODE != 0);
    localparam logic             ODD_PARITY = (PARITY_MODE == 1);

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // ------------------------------------------------------------------
    // Tick generator
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    assign tick = (div_cnt == DIV_LAST);

    // Free-running divider; never restarted by either FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    tx_state_t             tx_state;
    logic [CNT_W-1:0]      tx_cnt;
    logic [BIT_W-1:0]      tx_bit;
    logic                  tx_stop;
    logic                  tx_par;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic                  tx_line;
    logic                  tx_bit_end;

    assign tx_bit_end = tick && (tx_cnt == BIT_LAST);
    assign txd        = loopback ? 1'b1 : tx_line;

    // TX FSM: one bit period is OVERSAMPLE ticks, counted on the shared tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_stop  <= 1'b0;
            tx_par   <= 1'b0;
            tx_shift <= '0;
            tx_line  <= 1'b1;
            tx_ready <= 1'b1;
        end else begin
            if (tx_state != TX_IDLE && tick) begin
                tx_cnt <= tx_bit_end ? '0 : tx_cnt + 1'b1;
            end
            case (tx_state)
                TX_IDLE: begin
                    if (tx_valid && tx_ready) begin
                        tx_shift <= tx_data;
                        tx_par   <= ODD_PARITY ? ~^tx_data : ^tx_data;
                        tx_cnt   <= '0;
                        tx_line  <= 1'b0;
                        tx_ready <= 1'b0;
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_bit_end) begin
                        tx_line  <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                        tx_bit   <= '0;
                        tx_state <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (tx_bit_end) begin
                        if (tx_bit == DATA_LAST) begin
                            if (HAS_PARITY) begin
                                tx_line  <= tx_par;
                                tx_state <= TX_PARITY;
                            end else begin
                                tx_line  <= 1'b1;
                                tx_stop  <= 1'b0;
                                tx_state <= TX_STOP;
                            end
                        end else begin
                            tx_bit   <= tx_bit + 1'b1;
                            tx_line  <= tx_shift[0];
                            tx_shift <= tx_shift >> 1;
                        end
                    end
                end
                TX_PARITY: begin
                    if (tx_bit_end) begin
                        tx_line  <= 1'b1;
                        tx_stop  <= 1'b0;
                        tx_state <= TX_STOP;
                    end
                end
                TX_STOP: begin
                    if (tx_bit_end) begin
                        if (tx_stop == STOP_LAST) begin
                            tx_ready <= 1'b1;
                            tx_state <= TX_IDLE;
                        end else begin
                            tx_stop <= 1'b1;
                        end
                    end
                end
                default: begin
                    tx_line  <= 1'b1;
                    tx_ready <= 1'b1;
                    tx_state <= TX_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic                  rx_line;
    logic                  rx_meta;
    logic                  rx_sync;
    logic                  rx_prev;
    rx_state_t             rx_state;
    logic [CNT_W-1:0]      rx_cnt;
    logic [BIT_W-1:0]      rx_bit;
    logic                  rx_stop;
    logic                  rx_perr;
    logic                  rx_ferr;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic                  rx_half;
    logic                  rx_full;

    assign rx_line = loopback ? tx_line : rxd;
    assign rx_half = tick && (rx_cnt == HALF_LAST);
    assign rx_full = tick && (rx_cnt == BIT_LAST);

    // Two-flop synchroniser plus a history flop for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx_line;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // RX FSM: validate start at half a bit, then sample every full bit period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state      <= RX_IDLE;
            rx_cnt        <= '0;
            rx_bit        <= '0;
            rx_stop       <= 1'b0;
            rx_perr       <= 1'b0;
            rx_ferr       <= 1'b0;
            rx_shift      <= '0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (rx_state != RX_IDLE && tick) begin
                if (rx_state == RX_START) begin
                    rx_cnt <= rx_half ? '0 : rx_cnt + 1'b1;
                end else begin
                    rx_cnt <= rx_full ? '0 : rx_cnt + 1'b1;
                end
            end
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_half) begin
                        if (rx_sync) begin
                            rx_state <= RX_IDLE;
                        end else begin
                            rx_bit   <= '0;
                            rx_stop  <= 1'b0;
                            rx_perr  <= 1'b0;
                            rx_ferr  <= 1'b0;
                            rx_state <= RX_DATA;
                        end
                    end
                end
                RX_DATA: begin
                    if (rx_full) begin
                        rx_shift <= {rx_sync, rx_shift[DATA_WIDTH-1:1]};
                        if (rx_bit == DATA_LAST) begin
                            rx_state <= HAS_PARITY ? RX_PARITY : RX_STOP;
                        end else begin
                            rx_bit <= rx_bit + 1'b1;
                        end
                    end
                end
                RX_PARITY: begin
                    if (rx_full) begin
                        rx_perr  <= rx_sync != (ODD_PARITY ? ~^rx_shift : ^rx_shift);
                        rx_state <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (rx_full) begin
                        if (rx_stop == STOP_LAST) begin
                            rx_data       <= rx_shift;
                            rx_parity_err <= rx_perr;
                            rx_frame_err  <= rx_ferr | ~rx_sync;
                            rx_valid      <= 1'b1;
                            rx_state      <= RX_IDLE;
                        end else begin
                            rx_ferr <= rx_ferr | ~rx_sync;
                            rx_stop <= 1'b1;
                        end
                    end
                end
                default: begin
                    rx_state <= RX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: directed-plus-random bench for uart_core.
// Frames are predicted from the line-format rules (start, LSB-first data,
// parity from a ones count, stop bits) and compared against what the
// design puts on txd or reports on its receive outputs.

module tb_uart_core;

    localparam int BIT_CLKS = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] tx_data, rx_data;
    logic       tx_valid, tx_ready, txd, rxd, loopback;
    logic       rx_valid, rx_parity_err, rx_frame_err;

    logic [7:0] tx_data2, rx_data2;
    logic       tx_valid2, tx_ready2, txd2, rxd2, loopback2;
    logic       rx_valid2, rx_parity_err2, rx_frame_err2;

    uart_core #(
        .CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .DATA_WIDTH(8),
        .PARITY_MODE(2), .STOP_WIDTH(1), .OVERSAMPLE(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .txd(txd), .rxd(rxd), .loopback(loopback),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err)
    );

    uart_core #(
        .CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .DATA_WIDTH(8),
        .PARITY_MODE(1), .STOP_WIDTH(2), .OVERSAMPLE(16)
    ) dut2 (
        .clk(clk), .rst_n(rst_n),
        .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2),
        .txd(txd2), .rxd(rxd2), .loopback(loopback2),
        .rx_data(rx_data2), .rx_valid(rx_valid2),
        .rx_parity_err(rx_parity_err2), .rx_frame_err(rx_frame_err2)
    );

    int checks = 0;
    int fails  = 0;
    int cycle  = 0;
    int rd     = 0;

    // Cycle counter used to time accept-to-accept spacing.
    always @(posedge clk) cycle <= cycle + 1;

    logic [9:0] rx_log  [0:63];
    logic [9:0] rx2_log [0:63];
    int   rx_count     = 0;
    int   rx2_count    = 0;
    int   long_pulses  = 0;
    int   txd_viol     = 0;
    logic prev_valid   = 1'b0;
    logic prev_valid2  = 1'b0;

    // Receive monitor: logs every rx_valid pulse as {frame_err, parity_err, data}.
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            if (rx_count < 64) rx_log[rx_count] = {rx_frame_err, rx_parity_err, rx_data};
            rx_count = rx_count + 1;
            if (prev_valid) long_pulses = long_pulses + 1;
        end
        prev_valid = rx_valid;
        if (rx_valid2 === 1'b1) begin
            if (rx2_count < 64) rx2_log[rx2_count] = {rx_frame_err2, rx_parity_err2, rx_data2};
            rx2_count = rx2_count + 1;
            if (prev_valid2) long_pulses = long_pulses + 1;
        end
        prev_valid2 = rx_valid2;
        if (loopback === 1'b1 && txd !== 1'b1) txd_viol = txd_viol + 1;
        if (loopback2 === 1'b1 && txd2 !== 1'b1) txd_viol = txd_viol + 1;
    end

    // Reference frame: start bit, LSB-first data, optional parity, stop bits.
    function automatic logic [15:0] frame_bits(input logic [7:0] d, input int pmode,
                                               input int nstop, output int len);
        logic [15:0] f;
        int n;
        int ones;
        f = '0;
        n = 0;
        f[n] = 1'b0;
        n++;
        for (int i = 0; i < 8; i++) begin
            f[n] = d[i];
            n++;
        end
        ones = $countones(d);
        if (pmode == 1) begin
            f[n] = (ones % 2 == 0);
            n++;
        end else if (pmode == 2) begin
            f[n] = (ones % 2 == 1);
            n++;
        end
        for (int i = 0; i < nstop; i++) begin
            f[n] = 1'b1;
            n++;
        end
        len = n;
        return f;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one even-parity, one-stop frame on rxd, optionally corrupted.
    task automatic applyStimulus(input logic [7:0] d, input logic flip_par, input logic zero_stop);
        logic [15:0] f;
        int len;
        f = frame_bits(d, 2, 1, len);
        if (flip_par) f[9] = ~f[9];
        if (zero_stop) f[10] = 1'b0;
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            rxd = f[k];
            repeat (BIT_CLKS - 1) @(negedge clk);
        end
        @(negedge clk);
        rxd = 1'b1;
        repeat (3 * BIT_CLKS) @(negedge clk);
    endtask

    // Hands one byte to the first instance; returns at the negedge after accept.
    task automatic send_tx(input logic [7:0] d);
        @(negedge clk);
        checkOutput("tx_ready before accept", tx_ready, 1'b1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Waits (bounded) for the next logged frame and compares it to expectations.
    task automatic expect_rx(input string tag, input logic [7:0] d, input logic pe, input logic fe);
        int n;
        n = 0;
        while (rx_count <= rd && n < 600) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, " rx_valid seen"}, (rx_count > rd), 1'b1);
        if (rx_count > rd && rd < 64) begin
            checkOutput({tag, " rx_data"}, rx_log[rd][7:0], d);
            checkOutput({tag, " parity_err"}, rx_log[rd][8], pe);
            checkOutput({tag, " frame_err"}, rx_log[rd][9], fe);
        end
        rd = rx_count;
    endtask

    // Directed sequence with randomised payloads.
    initial begin
        logic [15:0] f;
        logic [7:0]  rb;
        logic [7:0]  b2 [0:3];
        logic        fp, fz;
        int          len, n, c0, acc, prev_acc, viol0, rd2;

        rst_n = 1'b0;
        tx_data = '0;  tx_valid = 1'b0;  rxd = 1'b1;  loopback = 1'b0;
        tx_data2 = '0; tx_valid2 = 1'b0; rxd2 = 1'b1; loopback2 = 1'b1;

        // Reset values
        repeat (3) @(negedge clk);
        checkOutput("reset txd", txd, 1'b1);
        checkOutput("reset tx_ready", tx_ready, 1'b1);
        checkOutput("reset rx_valid", rx_valid, 1'b0);
        checkOutput("reset rx_data", rx_data, 8'h00);
        checkOutput("reset parity_err", rx_parity_err, 1'b0);
        checkOutput("reset frame_err", rx_frame_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Asynchronous reset in the middle of a frame
        send_tx(8'h00);
        repeat (40) @(negedge clk);
        checkOutput("txd low mid-frame", txd, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async reset txd", txd, 1'b1);
        checkOutput("async reset tx_ready", tx_ready, 1'b1);
        checkOutput("async reset rx_valid", rx_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        c0 = rx_count;
        repeat (2 * 11 * BIT_CLKS) @(negedge clk);
        checkOutput("no rx_valid after reset", rx_count, c0);
        checkOutput("idle txd after reset", txd, 1'b1);
        rd = rx_count;

        // Serial TX waveform: 0xA5 then random bytes
        for (int t = 0; t < 4; t++) begin
            rb = (t == 0) ? 8'hA5 : 8'($urandom);
            f = frame_bits(rb, 2, 1, len);
            send_tx(rb);
            for (int k = 0; k < len; k++) begin
                repeat (BIT_CLKS / 2) @(posedge clk);
                @(negedge clk);
                checkOutput($sformatf("txd byte %0h bit %0d", rb, k), txd, f[k]);
                if (k == 0) checkOutput("tx_ready low in frame", tx_ready, 1'b0);
                if (k < len - 1) repeat (BIT_CLKS / 2) @(posedge clk);
            end
            repeat (BIT_CLKS / 2 - 1) @(posedge clk);
            @(negedge clk);
            checkOutput($sformatf("tx_ready still low %0h", rb), tx_ready, 1'b0);
            @(posedge clk);
            @(negedge clk);
            checkOutput($sformatf("tx_ready back %0h", rb), tx_ready, 1'b1);
        end
        rd = rx_count;

        // Internal loopback: 0xA5 then random bytes
        @(negedge clk);
        loopback = 1'b1;
        viol0 = txd_viol;
        for (int t = 0; t < 4; t++) begin
            rb = (t == 0) ? 8'hA5 : 8'($urandom);
            send_tx(rb);
            expect_rx($sformatf("loopback %0h", rb), rb, 1'b0, 1'b0);
            n = 0;
            while (tx_ready !== 1'b1 && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        checkOutput("txd held high in loopback", txd_viol, viol0);
        @(negedge clk);
        loopback = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        rd = rx_count;

        // External frames with parity and stop-bit corruption
        applyStimulus(8'h3C, 1'b1, 1'b0);
        expect_rx("rx 3C bad parity", 8'h3C, 1'b1, 1'b0);
        applyStimulus(8'h55, 1'b0, 1'b1);
        expect_rx("rx 55 bad stop", 8'h55, 1'b0, 1'b1);
        repeat (2 * BIT_CLKS) @(negedge clk);
        checkOutput("frame_err holds", rx_frame_err, 1'b1);
        checkOutput("rx_data holds", rx_data, 8'h55);
        for (int t = 0; t < 4; t++) begin
            rb = 8'($urandom);
            fp = 1'($urandom_range(0, 1));
            fz = 1'($urandom_range(0, 1));
            applyStimulus(rb, fp, fz);
            expect_rx($sformatf("rx random %0d", t), rb, fp, fz);
        end

        // Short low glitch is rejected, next frame still received
        c0 = rx_count;
        @(negedge clk);
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("glitch gives no rx_valid", rx_count, c0);
        applyStimulus(8'h81, 1'b0, 1'b0);
        expect_rx("rx 81 after glitch", 8'h81, 1'b0, 1'b0);

        // Back-to-back frames on the odd-parity, two-stop instance
        b2[0] = 8'h01;
        b2[1] = 8'h02;
        b2[2] = 8'($urandom);
        b2[3] = 8'($urandom);
        rd2 = rx2_count;
        prev_acc = 0;
        @(negedge clk);
        tx_data2  = b2[0];
        tx_valid2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (tx_ready2 !== 1'b1 && n < 400) begin
                @(negedge clk);
                n++;
            end
            checkOutput($sformatf("b2b ready %0d", i), tx_ready2, 1'b1);
            @(posedge clk);
            @(negedge clk);
            acc = cycle;
            checkOutput($sformatf("b2b accepted %0d", i), tx_ready2, 1'b0);
            if (i > 0) begin
                checkOutput($sformatf("b2b spacing %0d (gap %0d)", i, acc - prev_acc),
                            (acc - prev_acc >= 192 && acc - prev_acc <= 194), 1'b1);
            end
            prev_acc = acc;
            if (i < 3) tx_data2 = b2[i+1];
            else       tx_valid2 = 1'b0;
        end
        n = 0;
        while (rx2_count < rd2 + 4 && n < 800) begin
            @(negedge clk);
            n++;
        end
        checkOutput("b2b frames received", rx2_count - rd2, 4);
        for (int i = 0; i < 4; i++) begin
            if (rd2 + i < 64) begin
                checkOutput($sformatf("b2b rx %0d", i), rx2_log[rd2 + i], {2'b00, b2[i]});
            end
        end

        checkOutput("rx_valid single-cycle pulses", long_pulses, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/uart_core.md
Name: uart_core

Overview:
Single-clock, fully parametrised UART transceiver that replaces the derived-clock baud generator, TX and RX structure with clock-enable baud ticks. It adds valid/ready TX handshaking, an oversampled RX with start-bit validation, selectable parity, 1/2 stop bits and error flags. An internal loopback mode lets the design self-test without external wiring.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
BAUD_RATE, 9_600, line rate in bit/s
DATA_WIDTH, 8, payload bits per frame (5..9)
PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even
STOP_WIDTH, 1, stop bits (1 or 2)
OVERSAMPLE, 16, RX samples per bit (even, >= 8)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
tx_data  input  DATA_WIDTH  byte to transmit
tx_valid  input  1  tx_data valid
tx_ready  output  1  transmitter can accept a byte
txd  output  1  serial line out
rxd  input  1  serial line in (asynchronous)
loopback  input  1  1 = RX takes internal TX stream, txd pin held 1
rx_data  output  DATA_WIDTH  received byte
rx_valid  output  1  one-cycle pulse, rx_data and error flags valid
rx_parity_err  output  1  parity mismatch on the frame flagged by rx_valid
rx_frame_err  output  1  a stop bit sampled 0 on the frame flagged by rx_valid

Behaviour:
- Reset values: txd = 1, tx_ready = 1, rx_valid = 0, rx_data = 0, both error flags = 0, synchroniser flops = 1, all FSMs in IDLE, counters = 0. Reset is asynchronous at any point, including mid-frame: txd returns to 1 immediately.
- Tick generator: DIV = max(1, CLK_FREQ/(BAUD_RATE*OVERSAMPLE)), integer floor. A free-running counter gives a one-cycle tick every DIV clocks. One bit period = OVERSAMPLE ticks.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - tx_ready = 1 only in IDLE.
  - A byte is accepted when tx_valid && tx_ready; tx_data is latched on that edge.
  - The next cycle enters START: txd = 0 and tx_ready = 0.
  - DATA sends bits LSB first. PARITY is skipped when PARITY_MODE = 0. Odd parity makes the total count of ones (data + parity) odd; even parity makes it even.
  - STOP drives 1 for STOP_WIDTH bit periods, then returns to IDLE, where tx_ready = 1. tx_valid held high gives back-to-back frames with no extra idle bit.
  - Bit-period counting is aligned to the tick generator. The start bit may be up to one tick shorter than nominal. The tick counter is not restarted.
  - When loopback = 1, the txd pin is forced to 1 and the internal serial stream feeds RX.
- RX path: the source is selected by loopback, then passes through a 2-flop synchroniser.
- RX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: a 1->0 edge on the synchronised line moves to START and clears the tick count.
  - START: at OVERSAMPLE/2 ticks the line is re-sampled. If it is 1, this is a false start: return to IDLE with no output.
  - Each following bit is sampled once, OVERSAMPLE ticks after the previous sample (mid-bit).
  - PARITY (if enabled) compares the sample against the computed parity.
  - STOP samples STOP_WIDTH bits. Any stop bit sampled 0 sets frame_err.
  - At the mid-bit sample of the last stop bit: rx_data is updated, the flags are updated, rx_valid pulses for exactly 1 cycle, and the FSM returns to IDLE. Data is delivered even when errors are present.
  - The flags hold until the next rx_valid.
  - A frame error with the line held low does not re-trigger until the line has been 1 (edge detect).
- Loopback changes mid-frame are permitted. A corrupted frame is reported through the normal error flags; there is no hang.

Test Plan:
1. Reset: assert rst_n = 0 mid-transmission -> txd = 1, tx_ready = 1, rx_valid = 0 within the same cycle; no rx_valid for 2 frame times after release with rxd = 1.
2. Config CLK_FREQ = 1_600_000, BAUD = 100_000, OVERSAMPLE = 16, PARITY = 2, STOP = 1, loopback = 0; send 0xA5 -> txd, 16 clocks per bit: 0,1,0,1,0,0,1,0,1,0(parity),1; tx_ready high again 176±1 clocks after accept.
3. Same config, loopback = 1, send 0xA5 -> rx_valid single pulse, rx_data = 0xA5, both errors = 0; txd pin stays 1 throughout.
4. External rxd frame 0x3C with parity bit inverted -> rx_valid, rx_data = 0x3C, rx_parity_err = 1, rx_frame_err = 0; then a stop bit of 0 on 0x55 -> rx_frame_err = 1, rx_data = 0x55.
5. rxd low pulse of 4 clocks (below a half-bit) -> no rx_valid, RX back in IDLE; a valid 0x81 frame immediately afterwards is received correctly.
6. Back-to-back: tx_valid held with 0x01 then 0x02, STOP = 2, PARITY = 1 -> second byte accepted on the cycle tx_ready rises, no gap between frames; loopback receives 0x01 then 0x02 with no errors.
